ifft_reorder_out: RTL and testbench
===================================

Name: ifft_reorder_out

Overview:
- Output-side frame unloader for the spectral-multiply/IFFT chain. It is the reader counterpart to the per-sample input capture stage.
- Accepts one frame of N complex samples arriving in bit-reversed order from the transform core. It buffers them in a ping-pong memory, applies the 1/N output scaling with rounding, and streams the frame back out in natural order with out_valid.
- Sits between the IFFT butterfly core and the MC top-level outputs y_real/y_img.

Parameters:
- N, 256, frame length in samples; must be a power of two.
- LOG2N, 8, log2(N); sets counter and address width.
- W, 16, signed sample width for both real and imaginary parts.
- SCALE_SHIFT, 8, arithmetic right shift applied on output, range 0..W-1; 0 means bypass.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in_real/in_img; gaps between beats are allowed.
- in_real  input  W  signed real part, bit-reversed sample order.
- in_img  input  W  signed imaginary part, bit-reversed sample order.
- out_valid  output  1  qualifies y_real/y_img.
- y_real  output  W  signed real output, natural order, scaled.
- y_img  output  W  signed imaginary output, natural order, scaled.
- overflow  output  1  sticky flag: an input beat was dropped because both banks were full.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears wr_cnt, wr_bank, rd_cnt, rd_bank, both bank-full flags and the reader state.
  - Outputs go to out_valid=0, y_real=0, y_img=0, overflow=0.
  - A partial frame in progress is discarded. Memory contents need not be cleared.
- Storage: two banks of N x 2W bits, one bank per frame.
- Writer:
  - On each in_valid beat, if the current wr_bank is not full, store {in_real,in_img} at address bitrev(wr_cnt) over LOG2N bits, then increment wr_cnt.
  - When wr_cnt wraps from N-1 to 0: set full[wr_bank] and toggle wr_bank.
- Drop case: in_valid while full[wr_bank]=1 drops the sample, sets overflow, and leaves wr_cnt unchanged.
- Reader FSM has two states, R_IDLE and R_READ:
  - R_IDLE -> R_READ when any bank is full. Load rd_bank with the oldest full bank (the one written first) and set rd_cnt=0.
  - R_READ issues a synchronous read at address rd_cnt and increments rd_cnt each cycle.
  - On the edge where rd_cnt wraps from N-1: clear full[rd_bank] and toggle rd_bank.
    - If the other bank is full, stay in R_READ with no bubble, giving back-to-back frames.
    - Otherwise go to R_IDLE.
- Latency and output timing:
  - out_valid rises exactly 2 clocks after the edge that captures the final beat of a frame, when the reader is idle.
  - out_valid then stays high for exactly N consecutive cycles per frame.
  - y_* are registered. When out_valid=0 they hold their last value.
- Scaling: out = (v + 2^(SCALE_SHIFT-1)) >>> SCALE_SHIFT, i.e. round half up, computed at W+1 bits and then truncated to W. The result cannot overflow for SCALE_SHIFT>=1. With SCALE_SHIFT=0 the value is passed through unchanged.
- Simultaneous events:
  - Writer setting full[b] and reader clearing full[~b] in the same cycle both take effect.
  - The writer may write bank b in the same cycle the reader finishes b only after full[b] has cleared. A set on a bank that is still full is never possible because writes to full banks are blocked.
- overflow stays set until reset.

Test Plan:
- SCALE_SHIFT=0; one frame with in_real=k, in_img=-k for beat k=0..255, contiguous -> out_valid 2 cycles after beat 255. Outputs in order are (0,0), (128,-128), (64,-64), (192,-192), ...; the last output is (255,-255); out_valid is high for exactly 256 cycles.
- SCALE_SHIFT=8; inputs 0x7FFF, -32768, -129, 127, 128 at chosen positions -> outputs 128, -128, -1, 0, 1 at the bit-reversed natural positions.
- Three frames with random 0-3 cycle gaps, then two frames back-to-back -> outputs are continuous across frame boundaries with no bubble. Data matches the bit-reversal reference model and overflow stays 0.
- Write frames 1 and 2 while the reader is held busy, then send 5 beats of frame 3 during frame 1 readout -> frame-3 beats arriving before frame 1 finishes draining are dropped and overflow=1. Frames 1 and 2 are still output intact.
- Assert rst mid-write (beat 100) and again mid-read (output 50) -> out_valid drops to 0 asynchronously and all outputs read 0. The next full frame after release is output correctly, starting from natural index 0.

Source files
------------

// File: rtl/ifft_reorder_out_if.sv
// ifft_reorder_out_if
//   Sample stream bundle used on both sides of the IFFT output unloader.
//   One beat is a complex sample {data_real, data_img} qualified by valid.
//
//   Signals:
//     valid      beat qualifier
//     data_real  signed real part, W bits
//     data_img   signed imaginary part, W bits
//
//   Modports:
//     master  drives the stream
//     slave   receives the stream
interface ifft_reorder_out_if #(
    parameter int W = 16
);
    logic                valid;
    logic signed [W-1:0] data_real;
    logic signed [W-1:0] data_img;

    modport master (output valid, data_real, data_img);
    modport slave  (input  valid, data_real, data_img);
endinterface

// File: rtl/ifft_reorder_out.sv
// ifft_reorder_out
//   Output-side frame unloader for the spectral-multiply / IFFT chain.
//   Collects one frame of N complex samples delivered in bit-reversed order
//   into a ping-pong buffer, then streams each frame out in natural order
//   with 1/N scaling (round half up) applied on the way out.
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     in_if     slave stream: valid / data_real / data_img, bit-reversed order
//     out_if    master stream: out_valid / y_real / y_img, natural order, scaled
//     overflow  sticky; set when an input beat was dropped because both
//               banks were still holding unread frames
module ifft_reorder_out #(
    parameter int N           = 256,
    parameter int LOG2N       = 8,
    parameter int W           = 16,
    parameter int SCALE_SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    ifft_reorder_out_if.slave  in_if,
    ifft_reorder_out_if.master out_if,
    output logic               overflow
);

    typedef enum logic {
        R_IDLE,
        R_READ
    } rd_state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Half an output LSB for round-half-up; evaluates to zero when no
    // shift is requested, which turns the scaler into a pass-through.
    localparam int                ROUND_INT = (2 ** SCALE_SHIFT) / 2;
    localparam logic signed [W:0] ROUND     = (W + 1)'(ROUND_INT);

    // Two banks of N words, addressed as {bank, index}.
    logic [2*W-1:0] mem [0:2*N-1];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       full_q, full_d;
    logic             overflow_q, overflow_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     y_real_q, y_real_d;
    logic [W-1:0]     y_img_q, y_img_d;

    logic             wr_en;
    logic [LOG2N:0]   wr_addr;
    logic [1:0]       set_full;
    logic [1:0]       clr_full;
    logic [2*W-1:0]   rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Sign-extend by one bit so the rounding add cannot wrap, then shift
    // arithmetically; the top bit is redundant after any shift >= 1.
    function automatic logic [W-1:0] scale_sample(input logic [W-1:0] v);
        logic signed [W:0] sum;
        sum = $signed({v[W-1], v}) + ROUND;
        return W'(sum >>> SCALE_SHIFT);
    endfunction

    // Writer: place each accepted beat at its bit-reversed slot so the
    // reader can walk addresses linearly. A beat aimed at a bank that is
    // still waiting to be read is discarded and flagged.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        set_full   = 2'b00;
        wr_addr    = {wr_bank_q, bitrev(wr_cnt_q)};
        if (in_if.valid) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_IDX) begin
                    set_full[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                end
            end
        end
    end

    // Reader: once a bank fills, stream it out in address order. At the
    // end of a frame, continue straight into the other bank if it is
    // already waiting so consecutive frames leave without a gap.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = 1'b0;
        y_real_d    = y_real_q;
        y_img_d     = y_img_q;
        clr_full    = 2'b00;
        rd_word     = mem[{rd_bank_q, rd_cnt_q}];

        case (rd_state_q)
            R_IDLE: begin
                if (|full_q) begin
                    rd_state_d = R_READ;
                    rd_cnt_d   = '0;
                    // With both banks full the writer pointer has come back
                    // around to the bank that was filled first.
                    rd_bank_d  = (&full_q) ? wr_bank_q : full_q[1];
                end
            end
            R_READ: begin
                out_valid_d = 1'b1;
                y_real_d    = scale_sample(rd_word[2*W-1:W]);
                y_img_d     = scale_sample(rd_word[W-1:0]);
                rd_cnt_d    = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    clr_full[rd_bank_q] = 1'b1;
                    rd_bank_d           = ~rd_bank_q;
                    if (!full_q[~rd_bank_q]) begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        // Writer sets and reader clears always land on different banks.
        full_d = (full_q | set_full) & ~clr_full;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            overflow_q  <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            y_real_q    <= '0;
            y_img_q     <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            y_real_q    <= y_real_d;
            y_img_q     <= y_img_d;
        end
    end

    // Sample storage carries no reset; stale contents are never read
    // because a bank is only read after it has been completely rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {in_if.data_real, in_if.data_img};
        end
    end

    assign out_if.valid     = out_valid_q;
    assign out_if.data_real = y_real_q;
    assign out_if.data_img  = y_img_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_ifft_reorder_out.sv
// tb_ifft_reorder_out
//   Self-checking bench for ifft_reorder_out. Two instances share one input
//   stream: one with no output shift and one with an 8-bit shift. A frame
//   level reference model predicts, for every clock, whether a sample should
//   be leaving the block, which sample it is, and whether overflow is set.
`timescale 1ns/1ps
module tb_ifft_reorder_out;

    localparam int N     = 256;
    localparam int LOG2N = 8;
    localparam int W     = 16;

    logic clk;
    logic rst;
    logic ovf0;
    logic ovf8;

    ifft_reorder_out_if #(.W(W)) in_bus ();
    ifft_reorder_out_if #(.W(W)) out0_bus ();
    ifft_reorder_out_if #(.W(W)) out8_bus ();

    ifft_reorder_out #(.N(N), .LOG2N(LOG2N), .W(W), .SCALE_SHIFT(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_bus),
        .out_if   (out0_bus),
        .overflow (ovf0)
    );

    ifft_reorder_out #(.N(N), .LOG2N(LOG2N), .W(W), .SCALE_SHIFT(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_if    (in_bus),
        .out_if   (out8_bus),
        .overflow (ovf8)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur_run  = 0;
    int max_run  = 0;

    // Reference model state: completed-frame end times since the last
    // reset, the frame being assembled, and the expected raw sample per
    // output clock.
    int             frame_end [$];
    logic [W-1:0]   part_re [$];
    logic [W-1:0]   part_im [$];
    logic [2*W-1:0] exp_raw [int];
    logic [2*W-1:0] last_raw;
    logic           exp_ovf;

    logic [W-1:0] fr_re [N];
    logic [W-1:0] fr_im [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Longest unbroken run of valid outputs, used for the no-bubble check.
    always @(negedge clk) begin
        if (out0_bus.valid) cur_run = cur_run + 1;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
    end

    function automatic int bitrev_ref(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] scale_ref(input logic [W-1:0] v, input int s);
        int x;
        x = int'($signed(v));
        if (s > 0) x = (x + (1 << (s - 1))) >>> s;
        return W'(x);
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    // A beat landing on clock edge x. A frame drains over N clocks starting
    // two clocks after its last beat, or right after the previous frame if
    // that one is still draining. A beat is refused while the frame two
    // back (same bank) has not yet finished leaving.
    function automatic void model_beat(input int x, input logic [W-1:0] re, input logic [W-1:0] im);
        int k;
        int s;
        k = frame_end.size();
        if (k >= 2 && frame_end[k-2] >= x) begin
            exp_ovf = 1'b1;
            return;
        end
        part_re.push_back(re);
        part_im.push_back(im);
        if (part_re.size() == N) begin
            if (k >= 1 && x < frame_end[k-1]) s = frame_end[k-1] + 1;
            else s = x + 2;
            for (int j = 0; j < N; j++) begin
                exp_raw[s + j] = {part_re[bitrev_ref(j)], part_im[bitrev_ref(j)]};
            end
            frame_end.push_back(s + N - 1);
            part_re.delete();
            part_im.delete();
        end
    endfunction

    function automatic void model_reset();
        frame_end.delete();
        part_re.delete();
        part_im.delete();
        exp_raw.delete();
        last_raw = '0;
        exp_ovf  = 1'b0;
    endfunction

    task automatic compare_cycle();
        logic exp_v;
        exp_v = (exp_raw.exists(cyc) != 0);
        if (exp_v) last_raw = exp_raw[cyc];
        checkOutput("valid0", W'(out0_bus.valid), W'(exp_v));
        checkOutput("valid8", W'(out8_bus.valid), W'(exp_v));
        checkOutput("re0", out0_bus.data_real, scale_ref(last_raw[2*W-1:W], 0));
        checkOutput("im0", out0_bus.data_img, scale_ref(last_raw[W-1:0], 0));
        checkOutput("re8", out8_bus.data_real, scale_ref(last_raw[2*W-1:W], 8));
        checkOutput("im8", out8_bus.data_img, scale_ref(last_raw[W-1:0], 8));
        checkOutput("ovf0", W'(ovf0), W'(exp_ovf));
        checkOutput("ovf8", W'(ovf8), W'(exp_ovf));
    endtask

    // Drive one clock of input, advance past the edge and compare.
    task automatic applyStimulus(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
        in_bus.valid     = v;
        in_bus.data_real = re;
        in_bus.data_img  = im;
        if (v && !rst) model_beat(cyc + 1, re, im);
        @(posedge clk);
        cyc++;
        #1;
        compare_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0);
    endtask

    task automatic send_beats(input int first, input int count, input int max_gap);
        for (int k = first; k < first + count; k++) begin
            applyStimulus(1'b1, fr_re[k], fr_im[k]);
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = W'($urandom);
            fr_im[k] = W'($urandom);
        end
    endtask

    // Raise reset between clock edges, confirm outputs clear at once,
    // hold for a few clocks and release between edges.
    task automatic pulse_reset(input int hold);
        in_bus.valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_valid0", W'(out0_bus.valid), '0);
        checkOutput("rst_valid8", W'(out8_bus.valid), '0);
        checkOutput("rst_re0", out0_bus.data_real, '0);
        checkOutput("rst_im0", out0_bus.data_img, '0);
        checkOutput("rst_re8", out8_bus.data_real, '0);
        checkOutput("rst_im8", out8_bus.data_img, '0);
        checkOutput("rst_ovf0", W'(ovf0), '0);
        model_reset();
        idle(hold);
        rst = 1'b0;
    endtask

    logic [W-1:0] special [5];
    logic [W-1:0] special_out [5];
    int           valid_count;

    initial begin
        rst              = 1'b0;
        in_bus.valid     = 1'b0;
        in_bus.data_real = '0;
        in_bus.data_img  = '0;
        model_reset();
        pulse_reset(3);
        idle(4);

        // Ramp frame through the unscaled instance.
        for (int k = 0; k < N; k++) begin
            fr_re[k] = W'(k);
            fr_im[k] = W'(-k);
        end
        send_beats(0, N, 0);
        idle(1);
        checkOutput("ramp_gap_valid", W'(out0_bus.valid), W'(0));
        idle(1);
        checkOutput("ramp_first_valid", W'(out0_bus.valid), W'(1));
        checkOutput("ramp_first_re", out0_bus.data_real, W'(0));
        idle(1);
        checkOutput("ramp_second_re", out0_bus.data_real, W'(128));
        checkOutput("ramp_second_im", out0_bus.data_img, W'(-128));
        valid_count = 2;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            if (out0_bus.valid) valid_count++;
        end
        checkOutput("ramp_valid_count", W'(valid_count), W'(N));
        checkOutput("ramp_last_re", out0_bus.data_real, W'(255));
        checkOutput("ramp_last_im", out0_bus.data_img, W'(-255));

        // Rounding corners through the shifted instance, placed at the
        // first five natural output positions.
        special[0] = 16'h7FFF; special_out[0] = W'(128);
        special[1] = 16'h8000; special_out[1] = W'(-128);
        special[2] = W'(-129); special_out[2] = W'(-1);
        special[3] = W'(127);  special_out[3] = W'(0);
        special[4] = W'(128);  special_out[4] = W'(1);
        randomize_frame();
        for (int j = 0; j < 5; j++) begin
            fr_re[bitrev_ref(j)] = special[j];
            fr_im[bitrev_ref(j)] = special[j];
        end
        send_beats(0, N, 0);
        idle(1);
        for (int j = 0; j < 5; j++) begin
            idle(1);
            checkOutput($sformatf("scaled_re%0d", j), out8_bus.data_real, special_out[j]);
            checkOutput($sformatf("scaled_im%0d", j), out8_bus.data_img, special_out[j]);
        end
        idle(N);

        // Gappy frames, then two frames with no gap at all.
        for (int f = 0; f < 3; f++) begin
            randomize_frame();
            send_beats(0, N, 3);
        end
        idle(N + 10);
        max_run = 0;
        randomize_frame();
        send_beats(0, N, 0);
        randomize_frame();
        send_beats(0, N, 0);
        idle(N + 10);
        checkOutput("b2b_run", W'(max_run), W'(2 * N));
        checkOutput("b2b_ovf", W'(ovf0), W'(0));

        // Two buffered frames, then beats of a third arriving before the
        // first has drained.
        randomize_frame();
        send_beats(0, N, 0);
        randomize_frame();
        send_beats(0, N, 0);
        randomize_frame();
        send_beats(0, 5, 0);
        checkOutput("drop_ovf0", W'(ovf0), W'(1));
        checkOutput("drop_ovf8", W'(ovf8), W'(1));
        idle(2 * N + 10);

        // Reset part way into a frame, then part way into a readout.
        randomize_frame();
        send_beats(0, 100, 0);
        pulse_reset(2);
        randomize_frame();
        send_beats(0, N, 0);
        idle(52);
        pulse_reset(2);
        randomize_frame();
        send_beats(0, N, 0);
        idle(2);
        checkOutput("after_rst_valid", W'(out0_bus.valid), W'(1));
        checkOutput("after_rst_re", out0_bus.data_real, fr_re[0]);
        checkOutput("after_rst_im", out0_bus.data_img, fr_im[0]);
        idle(N + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
